lvds_lane_align_ctrl: RTL
=========================

// Module: lvds_lane_align_ctrl
// PURPOSE
//  Training sequencer for the sensor LVDS receive path, after the SERDES/IDELAY
//  primitives and before the word-check/bitslip stage.
//  Aligns LANES lanes one at a time against a fixed training word:
//   1) sweep the IDELAY taps and load the centre of the widest good window;
//   2) issue bitslip pulses until the deserialised word equals TRAIN_PAT.
//  Reports per-lane failure and overall completion.
// PARAMETERS
//  LANES      4         number of data lanes
//  WORD_W     12        deserialised bits per lane
//  TAP_W      5         IDELAY tap width; taps 0..2**TAP_W-1
//  TRAIN_PAT  12'hF00   training word, WORD_W bits
//  SETTLE     16        idle cycles after any tap load or bitslip
//  CHECK_CNT  64        valid words sampled per tap
// PORTS
//  I_clk         in   1              system clock
//  I_rst         in   1              synchronous reset, active-high
//  I_start       in   1              pulse: begin training (accepted only in IDLE/DONE)
//  I_data_valid  in   1              qualifies I_data
//  I_data        in   LANES*WORD_W   lane k = bits [k*WORD_W +: WORD_W]
//  O_dly_tap     out  TAP_W          tap value, valid while O_dly_ld is non-zero
//  O_dly_ld      out  LANES          one-hot tap-load strobe, 1 cycle
//  O_bitslip     out  LANES          one-hot bitslip strobe, 1 cycle
//  O_busy        out  1              training in progress
//  O_done        out  1              training finished (held high)
//  O_fail        out  LANES          per-lane failure, valid when O_done=1
// BEHAVIOUR
//  Reset: every output is 0; FSM goes to IDLE; lane index, tap counter, window
//   registers and all other counters clear. Reset in mid-sequence aborts on the
//   next edge; no further strobes are issued.
//  FSM states: IDLE, LOAD, SETTLE, SAMPLE, NEXT_TAP, CENTER, SLIP_WAIT,
//   SLIP_CHK, SLIP, NEXT_LANE, DONE. O_busy=1 in every state except IDLE and DONE.
//  IDLE/DONE + I_start -> LOAD. Lane=0, tap=0; O_done and O_fail clear in the
//   same edge. I_start is ignored in all other states.
//  LOAD: O_dly_ld[lane]=1 and O_dly_tap=tap for exactly 1 cycle -> SETTLE.
//  SETTLE: SETTLE cycles -> SAMPLE.
//  SAMPLE: collect CHECK_CNT words with I_data_valid=1 on the selected lane.
//   Invalid cycles do not count; there is no timeout.
//   The tap is good iff every sampled word equals the first sampled word AND that
//   word is a circular rotation of TRAIN_PAT (any of the WORD_W rotations).
//  NEXT_TAP: update the window tracker -> LOAD with tap+1, or -> CENTER after the
//   last tap. The tap counter does not wrap.
//   Tracker: current run (start, len) and best run. A strictly longer run
//   replaces the best, so on a tie the lowest-start run wins.
//   A run that is still open at the last tap is closed before CENTER.
//  CENTER:
//   - best len=0: set O_fail[lane]=1 -> NEXT_LANE, no slip phase.
//   - otherwise: load tap = best_start + (best_len-1)>>1 (1-cycle O_dly_ld)
//     -> SLIP_WAIT.
//  SLIP_WAIT: SETTLE cycles -> SLIP_CHK.
//  SLIP_CHK: take the next valid word.
//   - equals TRAIN_PAT: -> NEXT_LANE.
//   - mismatch with slips < WORD_W: -> SLIP.
//   - mismatch with slips = WORD_W: set O_fail[lane]=1 -> NEXT_LANE.
//  SLIP: O_bitslip[lane]=1 for 1 cycle; slips++ -> SLIP_WAIT.
//  NEXT_LANE: clear tap, slips and tracker.
//   - lane < LANES-1: lane++ -> LOAD.
//   - otherwise: -> DONE with O_done=1.
//  At most one bit of O_dly_ld | O_bitslip is high in any cycle.
//  Earlier lanes keep their last loaded tap; O_fail bits persist until the next
//   accepted start.
// TESTING
//  T1 reset: assert I_rst mid-SAMPLE -> next cycle all outputs 0; no strobes until
//     a new I_start.
//  T2 eye: model lane0 good for taps 9..17 -> centre tap 13 loaded. With good taps
//     {3,4,20..23} -> tap 21.
//  T3 slip: lane offset 5 bits -> exactly 7 O_bitslip pulses (12-5), each followed
//     by >=SETTLE quiet cycles, then the lane passes.
//  T4 dead lane: lane2 data random -> O_fail=4'b0100, no bitslip on lane2, lanes 0,1,3
//     still trained, O_done=1.
//  T5 unslippable: good eye but data never equals TRAIN_PAT after rotation (stuck
//     bit) -> 12 slips, then O_fail[lane]=1.
//  T6 handshake: I_start while busy is ignored. I_data_valid duty 1/3 -> SAMPLE
//     lasts ~3*CHECK_CNT cycles with identical results. I_start in DONE retrains and
//     clears O_fail.

Source files
------------

// File: rtl/lvds_lane_align_ctrl.sv
// LVDS receive training sequencer: per-lane IDELAY eye sweep that loads the
// centre of the widest good window, then bitslips until the word matches TRAIN_PAT.
module lvds_lane_align_ctrl #(
  parameter int                LANES     = 4,
  parameter int                WORD_W    = 12,
  parameter int                TAP_W     = 5,
  parameter logic [WORD_W-1:0] TRAIN_PAT = 12'hF00,
  parameter int                SETTLE    = 16,
  parameter int                CHECK_CNT = 64
) (
  input  logic                    I_clk,
  input  logic                    I_rst,
  input  logic                    I_start,
  input  logic                    I_data_valid,
  input  logic [LANES*WORD_W-1:0] I_data,
  output logic [TAP_W-1:0]        O_dly_tap,
  output logic [LANES-1:0]        O_dly_ld,
  output logic [LANES-1:0]        O_bitslip,
  output logic                    O_busy,
  output logic                    O_done,
  output logic [LANES-1:0]        O_fail
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LEN_W  = TAP_W + 1;
  localparam int WAIT_W = $clog2(SETTLE + 1);
  localparam int SMP_W  = $clog2(CHECK_CNT + 1);
  localparam int SLIP_W = $clog2(WORD_W + 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_SAMPLE,
    ST_NEXT_TAP,
    ST_CENTER,
    ST_SLIP_WAIT,
    ST_SLIP_CHK,
    ST_SLIP,
    ST_NEXT_LANE,
    ST_DONE
  } state_t;

  state_t              state_q;
  logic [LANE_W-1:0]   lane_q;
  logic [TAP_W-1:0]    tap_q;
  logic [WAIT_W-1:0]   waitCnt_q;
  logic [SMP_W-1:0]    sampleCnt_q;
  logic [SLIP_W-1:0]   slipCnt_q;
  logic [WORD_W-1:0]   firstWord_q;
  logic                tapGood_q;
  logic [TAP_W-1:0]    runStart_q;
  logic [LEN_W-1:0]    runLen_q;
  logic [TAP_W-1:0]    bestStart_q;
  logic [LEN_W-1:0]    bestLen_q;
  logic [TAP_W-1:0]    dlyTap_q;
  logic [LANES-1:0]    dlyLd_q;
  logic [LANES-1:0]    bitslip_q;
  logic                busy_q;
  logic                done_q;
  logic [LANES-1:0]    fail_q;

  logic [TAP_W-1:0]    runStart_d;
  logic [LEN_W-1:0]    runLen_d;
  logic [TAP_W-1:0]    bestStart_d;
  logic [LEN_W-1:0]    bestLen_d;
  logic [TAP_W-1:0]    centerTap_d;
  logic [TAP_W-1:0]    candStart;
  logic [LEN_W-1:0]    candLen;
  logic [WORD_W-1:0]   laneWord;
  logic                lastTap;

  // A tap only counts as good if the lane shows some rotation of the training word.
  function automatic logic isRotation(input logic [WORD_W-1:0] w);
    logic             hit;
    logic [WORD_W-1:0] rot;
    hit = 1'b0;
    for (int r = 0; r < WORD_W; r++) begin
      rot = (TRAIN_PAT << r) | (TRAIN_PAT >> (WORD_W - r));
      if (w == rot) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [LANES-1:0] laneBit(input logic [LANE_W-1:0] idx);
    return LANES'(1) << idx;
  endfunction

  assign laneWord = I_data[lane_q*WORD_W +: WORD_W];
  assign lastTap  = (tap_q == {TAP_W{1'b1}});

  // Window tracker next state; a run still open at the last tap is closed here too.
  always_comb begin
    runStart_d  = runStart_q;
    runLen_d    = runLen_q;
    candStart   = runStart_q;
    candLen     = '0;
    if (tapGood_q) begin
      if (runLen_q == '0) runStart_d = tap_q;
      runLen_d = runLen_q + 1'b1;
      if (lastTap) begin
        candStart = runStart_d;
        candLen   = runLen_d;
      end
    end else begin
      candLen  = runLen_q;
      runLen_d = '0;
    end
    bestStart_d = bestStart_q;
    bestLen_d   = bestLen_q;
    if (candLen > bestLen_q) begin
      bestStart_d = candStart;
      bestLen_d   = candLen;
    end
    centerTap_d = bestStart_d + TAP_W'((bestLen_d - 1'b1) >> 1);
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      tap_q       <= '0;
      waitCnt_q   <= '0;
      sampleCnt_q <= '0;
      slipCnt_q   <= '0;
      firstWord_q <= '0;
      tapGood_q   <= 1'b0;
      runStart_q  <= '0;
      runLen_q    <= '0;
      bestStart_q <= '0;
      bestLen_q   <= '0;
      dlyTap_q    <= '0;
      dlyLd_q     <= '0;
      bitslip_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= '0;
    end else begin
      dlyLd_q   <= '0;
      bitslip_q <= '0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (I_start) begin
            state_q     <= ST_LOAD;
            lane_q      <= '0;
            tap_q       <= '0;
            slipCnt_q   <= '0;
            runStart_q  <= '0;
            runLen_q    <= '0;
            bestStart_q <= '0;
            bestLen_q   <= '0;
            dlyTap_q    <= '0;
            dlyLd_q     <= laneBit('0);
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= '0;
          end
        end
        ST_LOAD: begin
          state_q   <= ST_SETTLE;
          waitCnt_q <= '0;
        end
        ST_SETTLE: begin
          if (waitCnt_q == WAIT_W'(SETTLE - 1)) begin
            state_q     <= ST_SAMPLE;
            sampleCnt_q <= '0;
          end else begin
            waitCnt_q <= waitCnt_q + 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (I_data_valid) begin
            if (sampleCnt_q == '0) begin
              firstWord_q <= laneWord;
              tapGood_q   <= isRotation(laneWord);
            end else if (laneWord != firstWord_q) begin
              tapGood_q <= 1'b0;
            end
            if (sampleCnt_q == SMP_W'(CHECK_CNT - 1)) begin
              state_q <= ST_NEXT_TAP;
            end else begin
              sampleCnt_q <= sampleCnt_q + 1'b1;
            end
          end
        end
        ST_NEXT_TAP: begin
          runStart_q  <= runStart_d;
          runLen_q    <= runLen_d;
          bestStart_q <= bestStart_d;
          bestLen_q   <= bestLen_d;
          if (lastTap) begin
            // The centre load strobe goes out during CENTER itself.
            state_q <= ST_CENTER;
            if (bestLen_d != '0) begin
              dlyTap_q <= centerTap_d;
              dlyLd_q  <= laneBit(lane_q);
            end
          end else begin
            state_q  <= ST_LOAD;
            tap_q    <= tap_q + 1'b1;
            dlyTap_q <= tap_q + 1'b1;
            dlyLd_q  <= laneBit(lane_q);
          end
        end
        ST_CENTER: begin
          if (bestLen_q == '0) begin
            fail_q[lane_q] <= 1'b1;
            state_q        <= ST_NEXT_LANE;
          end else begin
            state_q   <= ST_SLIP_WAIT;
            waitCnt_q <= '0;
          end
        end
        ST_SLIP_WAIT: begin
          if (waitCnt_q == WAIT_W'(SETTLE - 1)) begin
            state_q <= ST_SLIP_CHK;
          end else begin
            waitCnt_q <= waitCnt_q + 1'b1;
          end
        end
        ST_SLIP_CHK: begin
          if (I_data_valid) begin
            if (laneWord == TRAIN_PAT) begin
              state_q <= ST_NEXT_LANE;
            end else if (slipCnt_q == SLIP_W'(WORD_W)) begin
              fail_q[lane_q] <= 1'b1;
              state_q        <= ST_NEXT_LANE;
            end else begin
              state_q   <= ST_SLIP;
              bitslip_q <= laneBit(lane_q);
              slipCnt_q <= slipCnt_q + 1'b1;
            end
          end
        end
        ST_SLIP: begin
          state_q   <= ST_SLIP_WAIT;
          waitCnt_q <= '0;
        end
        ST_NEXT_LANE: begin
          tap_q       <= '0;
          slipCnt_q   <= '0;
          runStart_q  <= '0;
          runLen_q    <= '0;
          bestStart_q <= '0;
          bestLen_q   <= '0;
          if (lane_q != LANE_W'(LANES - 1)) begin
            state_q  <= ST_LOAD;
            lane_q   <= lane_q + 1'b1;
            dlyTap_q <= '0;
            dlyLd_q  <= laneBit(lane_q + 1'b1);
          end else begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign O_dly_tap = dlyTap_q;
  assign O_dly_ld  = dlyLd_q;
  assign O_bitslip = bitslip_q;
  assign O_busy    = busy_q;
  assign O_done    = done_q;
  assign O_fail    = fail_q;

endmodule
